// File: rtl/s820_bist_pkg.sv
// Shared BIST definitions for the s820 wrapper: compactor FSM states and the
// default signature constants also used by the upstream LFSR pattern generator.
package s820_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CMP  = 2'd2
    } state_t;

    localparam int          DEF_SIG_W = 24;
    localparam logic [23:0] DEF_POLY  = 24'hE10000;
    localparam logic [23:0] DEF_SEED  = 24'h000000;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift left, fold the polynomial in on MSB
// carry-out, then XOR the zero-extended response word into the low bits.
module misr_core #(
    parameter int               WIDTH = 19,
    parameter int               SIG_W = 24,
    parameter logic [SIG_W-1:0] POLY  = 24'hE10000,
    parameter logic [SIG_W-1:0] SEED  = 24'h000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] resp,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] resp_ext;
    logic [SIG_W-1:0] feedback;

    genvar gi;
    generate
        for (gi = 0; gi < SIG_W; gi++) begin : g_bit
            if (gi < WIDTH) begin : g_resp
                assign resp_ext[gi] = resp[gi];
            end else begin : g_pad
                assign resp_ext[gi] = 1'b0;
            end
            assign feedback[gi] = sig_q[SIG_W-1] & POLY[gi];
        end
    endgenerate

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ feedback ^ resp_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/s820_misr_compactor.sv
// Output-response compactor for the s820 core: sequences a counted MISR run
// under a START/DONE handshake and compares the final signature to a golden value.
module s820_misr_compactor
    import s820_bist_pkg::*;
#(
    parameter int               WIDTH = 19,
    parameter int               SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
    parameter int               CNT_W = 16
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] LEN,
    input  logic [WIDTH-1:0] RESP,
    input  logic             RESP_VALID,
    input  logic [SIG_W-1:0] EXP_SIG,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             sig_load;
    logic             sig_en;

    misr_core #(
        .WIDTH (WIDTH),
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (CK),
        .rst_n (RSTN),
        .load  (sig_load),
        .en    (sig_en),
        .resp  (RESP),
        .sig   (SIG)
    );

    // ABORT is checked first in every state so it wins over START and capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        sig_load = 1'b0;
        sig_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ABORT) begin
                    pass_d = 1'b0;
                end else if (START) begin
                    sig_load = 1'b1;
                    cnt_d    = LEN;
                    pass_d   = 1'b0;
                    state_d  = (LEN == '0) ? ST_CMP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (RESP_VALID) begin
                    sig_en = 1'b1;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                state_d = ST_IDLE;
                if (ABORT) begin
                    pass_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    pass_d = (SIG == EXP_SIG);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;

endmodule
